// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues reads to a synchronous imem,
// and feeds IF/ID through a one-entry skid buffer that absorbs hazard stalls.
module if_fetch_ctrl #(
    parameter int PC_WIDTH    = 7,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic                   imem_en,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   if_id_valid,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0]    if_id_pc,
    output logic [PC_WIDTH-1:0]    if_id_pc_next
);

    // State bits are {req_valid, skid_valid}; 2'b11 is never entered.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        FLOW = 2'b10
    } state_t;

    state_t                 state_q;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [PC_WIDTH-1:0]    req_pc;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic [PC_WIDTH-1:0]    skid_pc;

    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign imem_en       = rst_n & ~stall & ~redirect;
    assign if_id_pc_next = if_id_pc + PC_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            req_pc      <= '0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
        end else if (redirect) begin
            // In-flight and skid entries are dropped simply by clearing their valids.
            state_q     <= IDLE;
            pc_q        <= redirect_pc;
            if_id_valid <= 1'b0;
        end else if (stall) begin
            // Only a live memory response needs catching; an occupied skid is kept.
            if (state_q == FLOW) begin
                skid_instr <= imem_data;
                skid_pc    <= req_pc;
                state_q    <= HOLD;
            end
        end else begin
            case (state_q)
                HOLD: begin
                    if_id_instr <= skid_instr;
                    if_id_pc    <= skid_pc;
                    if_id_valid <= 1'b1;
                end
                FLOW: begin
                    if_id_instr <= imem_data;
                    if_id_pc    <= req_pc;
                    if_id_valid <= 1'b1;
                end
                default: if_id_valid <= 1'b0;
            endcase
            req_pc  <= pc_q;
            pc_q    <= pc_q + PC_WIDTH'(1);
            state_q <= FLOW;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized bench for if_fetch_ctrl against a queue-of-outstanding-addresses model.
module tb_if_fetch_ctrl;
    localparam int PW = 7;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst_n, stall, redirect;
    logic [PW-1:0] redirect_pc, imem_addr, pc, if_id_pc, if_id_pc_next;
    logic          imem_en, if_id_valid;
    logic [IW-1:0] imem_data, if_id_instr;

    int checks = 0;
    int errors = 0;

    // Model: addresses issued but not yet delivered, plus expected IF/ID contents.
    logic [PW-1:0] m_pc = '0;
    logic [PW-1:0] m_out_pc = '0;
    logic [IW-1:0] m_out_instr = '0;
    logic          m_valid = 1'b0;
    logic [PW-1:0] pend[$];

    always #5 clk = ~clk;

    if_fetch_ctrl #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_en(imem_en),
        .imem_data(imem_data), .pc(pc), .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc_next(if_id_pc_next)
    );

    // Synchronous memory; junk is returned after cycles without an issue.
    always @(posedge clk)
        imem_data <= imem_en ? (32'hA000_0000 + {25'b0, imem_addr}) : $urandom;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic d, input logic [PW-1:0] t);
        logic [PW-1:0] a;
        rst_n = r; stall = s; redirect = d; redirect_pc = t;
        #1;
        chk("imem_en", {63'b0, imem_en}, {63'b0, r & ~s & ~d});
        if (r) chk("imem_addr", {57'b0, imem_addr}, {57'b0, m_pc});
        if (!r) begin
            pend.delete();
            m_pc = '0; m_valid = 1'b0; m_out_pc = '0; m_out_instr = '0;
        end else if (d) begin
            pend.delete();
            m_pc = t; m_valid = 1'b0;
        end else if (!s) begin
            if (pend.size() > 0) begin
                a = pend.pop_front();
                m_valid = 1'b1; m_out_pc = a; m_out_instr = 32'hA000_0000 + {25'b0, a};
            end else begin
                m_valid = 1'b0;
            end
            pend.push_back(m_pc);
            m_pc = PW'(m_pc + 1);
        end
        @(posedge clk);
        @(negedge clk);
        chk("if_id_valid", {63'b0, if_id_valid}, {63'b0, m_valid});
        chk("if_id_instr", {32'b0, if_id_instr}, {32'b0, m_out_instr});
        chk("if_id_pc", {57'b0, if_id_pc}, {57'b0, m_out_pc});
        chk("if_id_pc_next", {57'b0, if_id_pc_next}, {57'b0, PW'(m_out_pc + 1)});
        chk("pc", {57'b0, pc}, {57'b0, m_pc});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        // Reset, then free run from address 0
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        run(6);
        // Wrap through 7F -> 00
        step(1'b1, 1'b0, 1'b1, 7'h7E);
        run(6);
        // Stall for three cycles while IF/ID holds pc 5
        step(1'b1, 1'b0, 1'b1, 7'h00);
        for (int i = 0; i < 20 && !(m_valid && m_out_pc == 7'd5); i++) run(1);
        chk("reach_pc5", {57'b0, if_id_pc}, 64'd5);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);
        run(4);
        // Redirect and stall together while in HOLD
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 7'h40);
        run(4);
        // Reset during HOLD, then restart from 0
        run(3);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        run(5);
        // Alternating stall
        for (int i = 0; i < 10; i++) step(1'b1, 1'(i % 2), 1'b0, '0);
        run(2);
        // Random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 35),
                 ($urandom_range(0, 99) < 8), PW'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch sequencer for the 1-instruction_fetch stage. It owns the program counter, issues word addresses to the synchronous instruction memory, and delivers fetched instructions to the IF/ID pipeline register. It absorbs hazard stalls through a one-entry skid buffer and handles branch/jump redirects. It consumes the PC-increment rule used across the fetch stage: next PC = PC + 1, modulo 2^PC_WIDTH.

## Interface
- PC_WIDTH, 7, program-counter and instruction-memory address width (word addressed)
- INSTR_WIDTH, 32, instruction width

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  one clock; reset is synchronous and active-low
- stall  in  1  hazard unit: IF/ID must hold this cycle
- redirect  in  1  taken branch/jump, flush fetch
- redirect_pc  in  PC_WIDTH  redirect target, sampled when redirect=1
- imem_addr  out  PC_WIDTH  memory address, = pc_q (combinational)
- imem_en  out  1  read issue, = rst_n & !stall & !redirect (combinational)
- imem_data  in  INSTR_WIDTH  memory data, valid the cycle after an issue
- pc  out  PC_WIDTH  current fetch PC (pc_q)
- if_id_valid  out  1  IF/ID holds a valid instruction
- if_id_instr  out  INSTR_WIDTH  fetched instruction
- if_id_pc  out  PC_WIDTH  address of if_id_instr
- if_id_pc_next  out  PC_WIDTH  if_id_pc + 1, wraps

## Operation
- Internal state: pc_q, req_valid/req_pc (an issue made last cycle, so imem_data is live now), skid_valid/skid_instr/skid_pc, and the IF/ID output registers.
- FSM encoded by {req_valid, skid_valid}:
  - IDLE (0,0): after reset or redirect.
  - FLOW (1,0): one request is in flight.
  - HOLD (0,1): skid buffer is full.
  - (1,1) is unreachable and must never occur.
- Per-cycle priority is rst_n, then redirect, then stall, then normal.
- Reset (rst_n=0):
  - pc_q, req_valid, skid_valid, if_id_valid, if_id_instr and if_id_pc are all 0, so if_id_pc_next=1.
  - imem_en=0. State goes to IDLE.
- Redirect (stall ignored):
  - pc_q <= redirect_pc.
  - req_valid, skid_valid and if_id_valid all <= 0.
  - No issue. State goes to IDLE.
  - Flushed skid and in-flight instructions are never emitted.
- Stall (no redirect):
  - IF/ID registers hold. No issue; pc_q holds.
  - If req_valid: skid_instr <= imem_data, skid_pc <= req_pc, skid_valid <= 1, req_valid <= 0. FLOW goes to HOLD.
  - In IDLE or HOLD the state is unchanged. The skid is never overwritten.
- Normal (stall=0, redirect=0):
  - If skid_valid: IF/ID <= skid, if_id_valid <= 1, skid_valid <= 0.
  - Else if req_valid: IF/ID <= {imem_data, req_pc}, if_id_valid <= 1.
  - Else: if_id_valid <= 0, and instr/pc hold their old values.
  - Always issue: req_valid <= 1, req_pc <= pc_q, pc_q <= pc_q + 1. State goes to FLOW.
- Arithmetic:
  - PC increments are PC_WIDTH bits with silent wrap (7'h7F + 1 = 7'h00).
  - if_id_pc_next follows the same rule and is derived combinationally from if_id_pc.
- Ordering: instructions reach IF/ID in strictly increasing (wrapping) address order between redirects, with no gap or duplicate caused by stall.

## Timing
- Fetch latency: address A issued in cycle t appears on if_id_* from cycle t+2 if no stall occurs.
- After rst_n rises with stall=0, the first valid instruction (pc 0) is on IF/ID two cycles later. Throughput is then one instruction per cycle.
- Redirect asserted in cycle t:
  - if_id_valid=0 from t+1.
  - Target issued at t+1.
  - Target instruction valid at t+3.
  - Penalty: 2 bubbles.
- Stall in cycle t: if_id_* at t+1 equals if_id_* at t.
- Stall release: the first non-stall cycle loads the skid entry, which is visible the next cycle. A fresh issue happens in the same cycle, so the bubble-free stream continues.
- Memory contract: imem_data reflects the address presented with imem_en=1 in the previous cycle. Data in cycles with no prior issue is ignored.

## Test plan
Memory model: mem[a] = 32'hA000_0000 + a.

- **Reset + free run:** rst_n=0 for 2 cycles, then release with stall=0 → two cycles later if_id_valid=1, instr=A000_0000, pc=0, pc_next=1; the next cycles give pc 1, 2, 3 consecutively.
- **Wrap:** redirect to 7'h7E → three cycles later pc=7E (pc_next=7F), then 7F (pc_next=00), then 00 with instr A000_0000.
- **Stall:** stall for 3 cycles while if_id_pc=5 → IF/ID holds pc 5 throughout; after release the stream is 6, 7, 8 with no gap or duplicate. imem_en=0 during the stall.
- **Redirect+stall collision:** stall=1 and redirect=1 in the same cycle while in HOLD, target 7'h40 → if_id_valid=0 next cycle, pc 7'h40 valid two cycles later, and the skid instruction never appears.
- **Reset mid-operation:** rst_n=0 during HOLD → next edge gives all outputs 0, pc=0, imem_en=0; the restart fetches from 0.
- **Alternating stall:** stall toggles every cycle for 10 cycles → each address appears exactly once, in order.
